// File: rtl/inst_queue.sv
// inst_queue: fetch-to-decode instruction FIFO, consumer side.
// Splits 2-wide fetch packets into single-instruction entries in a circular
// buffer and presents up to two in-order instructions per cycle to ID.
// Optional build macro INST_QUEUE_PERF_EN adds empty/full cycle counters.

`ifndef PC_RESET
`define PC_RESET 32'h1C000000
`endif
`ifndef INST_NOP
`define INST_NOP 32'h03400000
`endif

module inst_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        fifo_readygo,
    output logic        fifo_allowin,
    output logic        space_ok,
    output logic        nearly_full,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_pc_next,
    input  logic        in_pc_taken,
    input  logic [31:0] in_inst0,
    input  logic [31:0] in_inst1,
    input  logic [31:0] in_badv,
    input  logic [6:0]  in_exception,
    input  logic [1:0]  in_excp_flag,
    input  logic        id_allowin,
    output logic        out0_valid,
    output logic        out1_valid,
    output logic [31:0] out0_pc,
    output logic [31:0] out1_pc,
    output logic [31:0] out0_inst,
    output logic [31:0] out1_inst,
    output logic [31:0] out0_pc_next,
    output logic [31:0] out1_pc_next,
    output logic        out0_taken,
    output logic        out1_taken,
    output logic [31:0] out0_badv,
    output logic [31:0] out1_badv,
    output logic [6:0]  out0_exception,
    output logic [6:0]  out1_exception,
    output logic [1:0]  out0_excp_flag,
    output logic [1:0]  out1_excp_flag
`ifdef INST_QUEUE_PERF_EN
    ,
    output logic [31:0] iq_empty_cycles,
    output logic [31:0] iq_full_cycles
`endif
);

    localparam logic [PTR_W:0] SPACE_MAX = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W:0] NEAR_MIN  = (PTR_W+1)'(DEPTH - 3);

    // Entry storage, one field per array
    logic [31:0] pc_q      [DEPTH];
    logic [31:0] inst_q    [DEPTH];
    logic [31:0] pc_next_q [DEPTH];
    logic        taken_q   [DEPTH];
    logic [31:0] badv_q    [DEPTH];
    logic [6:0]  exc_q     [DEPTH];
    logic [1:0]  flag_q    [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] head_p1, tail_p1;

    logic       push;
    logic       single;
    logic [1:0] push_cnt;
    logic [1:0] pop_cnt;
    logic [31:0] pc_plus4;

    assign head_p1  = head_q + PTR_W'(1);
    assign tail_p1  = tail_q + PTR_W'(1);
    assign pc_plus4 = in_pc + 32'd4;

    // Backpressure only looks at the current occupancy; a same-cycle pop
    // never opens space for a push.
    assign space_ok     = (count_q <= SPACE_MAX);
    assign fifo_allowin = space_ok;
    assign nearly_full  = (count_q >= NEAR_MIN);

    assign out0_valid = (count_q != '0);
    assign out1_valid = (count_q >= (PTR_W+1)'(2));

    assign out0_pc        = pc_q[head_q];
    assign out0_inst      = inst_q[head_q];
    assign out0_pc_next   = pc_next_q[head_q];
    assign out0_taken     = taken_q[head_q];
    assign out0_badv      = badv_q[head_q];
    assign out0_exception = exc_q[head_q];
    assign out0_excp_flag = flag_q[head_q];

    assign out1_pc        = pc_q[head_p1];
    assign out1_inst      = inst_q[head_p1];
    assign out1_pc_next   = pc_next_q[head_p1];
    assign out1_taken     = taken_q[head_p1];
    assign out1_badv      = badv_q[head_p1];
    assign out1_exception = exc_q[head_p1];
    assign out1_excp_flag = flag_q[head_p1];

    // Push/pop sizing and next-state pointers
    always_comb begin
        push     = fifo_readygo && fifo_allowin;
        // Odd-slot PCs and faulting packets carry only one real instruction
        single   = in_pc[2] || (in_excp_flag != 2'b00);
        push_cnt = 2'd0;
        if (push) begin
            push_cnt = single ? 2'd1 : 2'd2;
        end
        pop_cnt = 2'd0;
        if (id_allowin) begin
            pop_cnt = {1'b0, out0_valid} + {1'b0, out1_valid};
        end
        tail_d  = tail_q + PTR_W'(push_cnt);
        head_d  = head_q + PTR_W'(pop_cnt);
        count_d = count_q + (PTR_W+1)'(push_cnt) - (PTR_W+1)'(pop_cnt);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry writes; flush leaves contents alone, only rst restores defaults
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]      <= `PC_RESET;
                inst_q[i]    <= `INST_NOP;
                pc_next_q[i] <= `PC_RESET + 32'd4;
                taken_q[i]   <= 1'b0;
                badv_q[i]    <= 32'd0;
                exc_q[i]     <= 7'd0;
                flag_q[i]    <= 2'd0;
            end
        end else if (push && !flush) begin
            pc_q[tail_q]   <= in_pc;
            inst_q[tail_q] <= in_inst0;
            badv_q[tail_q] <= in_badv;
            exc_q[tail_q]  <= in_exception;
            flag_q[tail_q] <= in_excp_flag;
            if (single) begin
                pc_next_q[tail_q] <= in_pc_next;
                taken_q[tail_q]   <= in_pc_taken;
            end else begin
                pc_next_q[tail_q]  <= pc_plus4;
                taken_q[tail_q]    <= 1'b0;
                pc_q[tail_p1]      <= pc_plus4;
                inst_q[tail_p1]    <= in_inst1;
                pc_next_q[tail_p1] <= in_pc_next;
                taken_q[tail_p1]   <= in_pc_taken;
                badv_q[tail_p1]    <= 32'd0;
                exc_q[tail_p1]     <= 7'd0;
                flag_q[tail_p1]    <= 2'd0;
            end
        end
    end

`ifdef INST_QUEUE_PERF_EN
    // Saturating occupancy counters, cleared only by rst
    always_ff @(posedge clk) begin
        if (rst) begin
            iq_empty_cycles <= 32'd0;
            iq_full_cycles  <= 32'd0;
        end else begin
            if ((count_q == '0) && !flush && (iq_empty_cycles != 32'hFFFF_FFFF)) begin
                iq_empty_cycles <= iq_empty_cycles + 32'd1;
            end
            if (!space_ok && (iq_full_cycles != 32'hFFFF_FFFF)) begin
                iq_full_cycles <= iq_full_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue (default build, DEPTH = 8).

`ifndef PC_RESET
`define PC_RESET 32'h1C000000
`endif
`ifndef INST_NOP
`define INST_NOP 32'h03400000
`endif

module tb_inst_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        fifo_readygo;
    logic        fifo_allowin;
    logic        space_ok;
    logic        nearly_full;
    logic [31:0] in_pc;
    logic [31:0] in_pc_next;
    logic        in_pc_taken;
    logic [31:0] in_inst0;
    logic [31:0] in_inst1;
    logic [31:0] in_badv;
    logic [6:0]  in_exception;
    logic [1:0]  in_excp_flag;
    logic        id_allowin;
    logic        out0_valid, out1_valid;
    logic [31:0] out0_pc, out1_pc;
    logic [31:0] out0_inst, out1_inst;
    logic [31:0] out0_pc_next, out1_pc_next;
    logic        out0_taken, out1_taken;
    logic [31:0] out0_badv, out1_badv;
    logic [6:0]  out0_exception, out1_exception;
    logic [1:0]  out0_excp_flag, out1_excp_flag;

    int checks;
    int failures;

    inst_queue #(
        .DEPTH(8),
        .PTR_W(3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .fifo_readygo   (fifo_readygo),
        .fifo_allowin   (fifo_allowin),
        .space_ok       (space_ok),
        .nearly_full    (nearly_full),
        .in_pc          (in_pc),
        .in_pc_next     (in_pc_next),
        .in_pc_taken    (in_pc_taken),
        .in_inst0       (in_inst0),
        .in_inst1       (in_inst1),
        .in_badv        (in_badv),
        .in_exception   (in_exception),
        .in_excp_flag   (in_excp_flag),
        .id_allowin     (id_allowin),
        .out0_valid     (out0_valid),
        .out1_valid     (out1_valid),
        .out0_pc        (out0_pc),
        .out1_pc        (out1_pc),
        .out0_inst      (out0_inst),
        .out1_inst      (out1_inst),
        .out0_pc_next   (out0_pc_next),
        .out1_pc_next   (out1_pc_next),
        .out0_taken     (out0_taken),
        .out1_taken     (out1_taken),
        .out0_badv      (out0_badv),
        .out1_badv      (out1_badv),
        .out0_exception (out0_exception),
        .out1_exception (out1_exception),
        .out0_excp_flag (out0_excp_flag),
        .out1_excp_flag (out1_excp_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input logic [31:0] pc, input logic [31:0] nxt, input logic tk,
                           input logic [31:0] i0, input logic [31:0] i1,
                           input logic [31:0] bv, input logic [6:0] ex,
                           input logic [1:0] fl);
        in_pc        = pc;
        in_pc_next   = nxt;
        in_pc_taken  = tk;
        in_inst0     = i0;
        in_inst1     = i1;
        in_badv      = bv;
        in_exception = ex;
        in_excp_flag = fl;
    endtask

    // One-cycle push of a plain packet (no exception)
    task automatic push_plain(input logic [31:0] pc, input logic [31:0] nxt, input logic tk,
                              input logic [31:0] i0, input logic [31:0] i1);
        set_pkt(pc, nxt, tk, i0, i1, 32'd0, 7'd0, 2'd0);
        fifo_readygo = 1'b1;
        tick();
        fifo_readygo = 1'b0;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        flush        = 1'b0;
        fifo_readygo = 1'b0;
        id_allowin   = 1'b0;
        set_pkt(32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 7'd0, 2'd0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out0_valid !== 1'b0) begin failures++; $display("FAIL rst_out0_valid got=%0b exp=0", out0_valid); end
        checks++; if (out1_valid !== 1'b0) begin failures++; $display("FAIL rst_out1_valid got=%0b exp=0", out1_valid); end
        checks++; if (space_ok !== 1'b1) begin failures++; $display("FAIL rst_space_ok got=%0b exp=1", space_ok); end
        checks++; if (fifo_allowin !== 1'b1) begin failures++; $display("FAIL rst_allowin got=%0b exp=1", fifo_allowin); end
        checks++; if (nearly_full !== 1'b0) begin failures++; $display("FAIL rst_nearly_full got=%0b exp=0", nearly_full); end
        checks++; if (out0_pc !== `PC_RESET) begin failures++; $display("FAIL rst_out0_pc got=%h exp=%h", out0_pc, `PC_RESET); end
        checks++; if (out0_inst !== `INST_NOP) begin failures++; $display("FAIL rst_out0_inst got=%h exp=%h", out0_inst, `INST_NOP); end
        checks++; if (out1_pc_next !== (`PC_RESET + 32'd4)) begin failures++; $display("FAIL rst_out1_pc_next got=%h exp=%h", out1_pc_next, `PC_RESET + 32'd4); end
        checks++; if (out0_badv !== 32'd0 || out0_excp_flag !== 2'd0 || out0_exception !== 7'd0 || out0_taken !== 1'b0) begin failures++; $display("FAIL rst_out0_fields got=%h/%h/%h/%b exp=0", out0_badv, out0_excp_flag, out0_exception, out0_taken); end
        checks++; if (dut.count_q !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", dut.count_q); end
    endtask

    task automatic test_two_wide();
        do_reset();
        push_plain(32'h1C000000, 32'h1C000008, 1'b0, 32'h11, 32'h22);
        checks++; if (out0_valid !== 1'b1 || out1_valid !== 1'b1) begin failures++; $display("FAIL two_valids got=%b%b exp=11", out0_valid, out1_valid); end
        checks++; if (out0_pc !== 32'h1C000000 || out0_inst !== 32'h11) begin failures++; $display("FAIL two_out0 got=%h/%h exp=1c000000/00000011", out0_pc, out0_inst); end
        checks++; if (out1_pc !== 32'h1C000004 || out1_inst !== 32'h22) begin failures++; $display("FAIL two_out1 got=%h/%h exp=1c000004/00000022", out1_pc, out1_inst); end
        checks++; if (out0_pc_next !== 32'h1C000004 || out0_taken !== 1'b0) begin failures++; $display("FAIL two_out0_next got=%h/%b exp=1c000004/0", out0_pc_next, out0_taken); end
        checks++; if (out1_pc_next !== 32'h1C000008) begin failures++; $display("FAIL two_out1_next got=%h exp=1c000008", out1_pc_next); end
        checks++; if (dut.count_q !== 4'd2) begin failures++; $display("FAIL two_count got=%0d exp=2", dut.count_q); end
    endtask

    task automatic test_single_taken();
        do_reset();
        push_plain(32'h1C000000, 32'h1C000008, 1'b0, 32'h11, 32'h22);
        push_plain(32'h1C000014, 32'h1C000100, 1'b1, 32'h33, 32'h03400000);
        checks++; if (dut.count_q !== 4'd3) begin failures++; $display("FAIL single_count got=%0d exp=3", dut.count_q); end
        // Pop the first packet to bring the single entry to out0
        id_allowin = 1'b1;
        tick();
        id_allowin = 1'b0;
        checks++; if (out0_pc !== 32'h1C000014 || out0_inst !== 32'h33) begin failures++; $display("FAIL single_out0 got=%h/%h exp=1c000014/00000033", out0_pc, out0_inst); end
        checks++; if (out0_taken !== 1'b1 || out0_pc_next !== 32'h1C000100) begin failures++; $display("FAIL single_pred got=%b/%h exp=1/1c000100", out0_taken, out0_pc_next); end
        checks++; if (out0_valid !== 1'b1 || out1_valid !== 1'b0) begin failures++; $display("FAIL single_valids got=%b%b exp=10", out0_valid, out1_valid); end
        id_allowin = 1'b1;
        tick();
        id_allowin = 1'b0;
        checks++; if (dut.count_q !== 4'd0 || out0_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%0d/%b exp=0/0", dut.count_q, out0_valid); end
        // Empty queue ignores id_allowin
        id_allowin = 1'b1;
        tick();
        id_allowin = 1'b0;
        checks++; if (dut.count_q !== 4'd0) begin failures++; $display("FAIL empty_pop got=%0d exp=0", dut.count_q); end
    endtask

    task automatic test_exception();
        do_reset();
        set_pkt(32'h1C000020, 32'h1C000028, 1'b0, 32'h44, 32'h55, 32'h1C000020, 7'h08, 2'b01);
        fifo_readygo = 1'b1;
        tick();
        fifo_readygo = 1'b0;
        checks++; if (dut.count_q !== 4'd1 || out1_valid !== 1'b0) begin failures++; $display("FAIL excp_count got=%0d/%b exp=1/0", dut.count_q, out1_valid); end
        checks++; if (out0_excp_flag !== 2'b01 || out0_exception !== 7'h08) begin failures++; $display("FAIL excp_code got=%b/%h exp=01/08", out0_excp_flag, out0_exception); end
        checks++; if (out0_badv !== 32'h1C000020 || out0_inst !== 32'h44) begin failures++; $display("FAIL excp_badv got=%h/%h exp=1c000020/00000044", out0_badv, out0_inst); end
        checks++; if (out0_pc_next !== 32'h1C000028) begin failures++; $display("FAIL excp_pc_next got=%h exp=1c000028", out0_pc_next); end
    endtask

    task automatic test_full();
        do_reset();
        push_plain(32'h1C000040, 32'h1C000048, 1'b0, 32'h40, 32'h41);
        push_plain(32'h1C000048, 32'h1C000050, 1'b0, 32'h48, 32'h49);
        checks++; if (nearly_full !== 1'b0 || space_ok !== 1'b1) begin failures++; $display("FAIL full_at4 got=%b/%b exp=0/1", nearly_full, space_ok); end
        push_plain(32'h1C000050, 32'h1C000058, 1'b0, 32'h50, 32'h51);
        checks++; if (nearly_full !== 1'b1 || space_ok !== 1'b1) begin failures++; $display("FAIL full_at6 got=%b/%b exp=1/1", nearly_full, space_ok); end
        push_plain(32'h1C000058, 32'h1C000060, 1'b0, 32'h58, 32'h59);
        checks++; if (space_ok !== 1'b0 || fifo_allowin !== 1'b0 || nearly_full !== 1'b1) begin failures++; $display("FAIL full_flags got=%b/%b/%b exp=0/0/1", space_ok, fifo_allowin, nearly_full); end
        // Held producer must be refused while full
        set_pkt(32'h1C000900, 32'h1C000908, 1'b0, 32'h99, 32'h9A, 32'd0, 7'd0, 2'd0);
        fifo_readygo = 1'b1;
        tick();
        tick();
        fifo_readygo = 1'b0;
        checks++; if (dut.count_q !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", dut.count_q); end
        checks++; if (out0_pc !== 32'h1C000040 || out1_pc !== 32'h1C000044) begin failures++; $display("FAIL full_head got=%h/%h exp=1c000040/1c000044", out0_pc, out1_pc); end
        checks++; if (dut.pc_q[0] !== 32'h1C000040) begin failures++; $display("FAIL full_no_overwrite got=%h exp=1c000040", dut.pc_q[0]); end
    endtask

    task automatic test_wrap();
        do_reset();
        push_plain(32'h1C000040, 32'h1C000048, 1'b0, 32'h40, 32'h41);
        push_plain(32'h1C000048, 32'h1C000050, 1'b0, 32'h48, 32'h49);
        push_plain(32'h1C000050, 32'h1C000058, 1'b0, 32'h50, 32'h51);
        push_plain(32'h1C000064, 32'h1C000068, 1'b0, 32'h66, 32'h03400000);
        id_allowin = 1'b1;
        tick();
        tick();
        tick();
        id_allowin = 1'b0;
        // head = 6, one entry left; next packet splits across entries 7 and 0
        push_plain(32'h1C000070, 32'h1C000078, 1'b0, 32'h77, 32'h78);
        checks++; if (dut.count_q !== 4'd3 || dut.tail_q !== 3'd1 || dut.head_q !== 3'd6) begin failures++; $display("FAIL wrap_pre got=c%0d t%0d h%0d exp=c3 t1 h6", dut.count_q, dut.tail_q, dut.head_q); end
        checks++; if (out0_pc !== 32'h1C000064 || out1_pc !== 32'h1C000070) begin failures++; $display("FAIL wrap_pre_out got=%h/%h exp=1c000064/1c000070", out0_pc, out1_pc); end
        checks++; if (dut.pc_q[0] !== 32'h1C000074 || dut.inst_q[0] !== 32'h78) begin failures++; $display("FAIL wrap_second got=%h/%h exp=1c000074/00000078", dut.pc_q[0], dut.inst_q[0]); end
        // Simultaneous push and pop
        set_pkt(32'h1C000080, 32'h1C000088, 1'b0, 32'h88, 32'h89, 32'd0, 7'd0, 2'd0);
        fifo_readygo = 1'b1;
        id_allowin   = 1'b1;
        tick();
        fifo_readygo = 1'b0;
        id_allowin   = 1'b0;
        checks++; if (dut.count_q !== 4'd3 || dut.tail_q !== 3'd3 || dut.head_q !== 3'd0) begin failures++; $display("FAIL wrap_post got=c%0d t%0d h%0d exp=c3 t3 h0", dut.count_q, dut.tail_q, dut.head_q); end
        checks++; if (out0_pc !== 32'h1C000074 || out0_inst !== 32'h78) begin failures++; $display("FAIL wrap_out0 got=%h/%h exp=1c000074/00000078", out0_pc, out0_inst); end
        checks++; if (out1_pc !== 32'h1C000080 || out1_inst !== 32'h88) begin failures++; $display("FAIL wrap_out1 got=%h/%h exp=1c000080/00000088", out1_pc, out1_inst); end
    endtask

    task automatic test_flush();
        do_reset();
        push_plain(32'h1C000040, 32'h1C000048, 1'b0, 32'h40, 32'h41);
        push_plain(32'h1C000048, 32'h1C000050, 1'b0, 32'h48, 32'h49);
        push_plain(32'h1C000054, 32'h1C000058, 1'b0, 32'h54, 32'h03400000);
        checks++; if (dut.count_q !== 4'd5) begin failures++; $display("FAIL flush_pre got=%0d exp=5", dut.count_q); end
        set_pkt(32'h1C000A00, 32'h1C000A08, 1'b0, 32'hAA, 32'hAB, 32'd0, 7'd0, 2'd0);
        fifo_readygo = 1'b1;
        id_allowin   = 1'b1;
        flush        = 1'b1;
        tick();
        fifo_readygo = 1'b0;
        id_allowin   = 1'b0;
        flush        = 1'b0;
        checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin failures++; $display("FAIL flush_valids got=%b%b exp=00", out0_valid, out1_valid); end
        checks++; if (dut.count_q !== 4'd0 || dut.head_q !== 3'd0 || dut.tail_q !== 3'd0) begin failures++; $display("FAIL flush_ptrs got=c%0d h%0d t%0d exp=0", dut.count_q, dut.head_q, dut.tail_q); end
        // Contents survive flush and the flushed push wrote nothing
        checks++; if (out0_pc !== 32'h1C000040 || out0_inst !== 32'h40) begin failures++; $display("FAIL flush_contents got=%h/%h exp=1c000040/00000040", out0_pc, out0_inst); end
        tick();
        checks++; if (out0_valid !== 1'b0 || space_ok !== 1'b1) begin failures++; $display("FAIL flush_lost got=%b/%b exp=0/1", out0_valid, space_ok); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_two_wide();
        test_single_taken();
        test_exception();
        test_full();
        test_wrap();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Consumer end of the fetch-to-decode instruction FIFO interface. It accepts the 2-wide fetch packets presented by the IF1 register stage and splits each one into per-instruction entries in a circular buffer.
- It hands up to two instructions per cycle, in order, to the ID stage.
- It drives the space_ok / nearly_full / fifo_allowin backpressure that the producer uses to stop fetching.

Parameters:
- DEPTH, 8, number of single-instruction entries; power of two, at least 4.
- PTR_W, 3, pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  reset: one clock domain, synchronous, active-high.
- flush  in  1  pipeline flush; clears the queue.
- fifo_readygo  in  1  producer packet valid.
- fifo_allowin  out  1  queue accepts a packet this cycle; equals space_ok.
- space_ok  out  1  free entries >= 2.
- nearly_full  out  1  free entries < 4.
- in_pc  in  32  packet PC.
- in_pc_next  in  32  predicted next-fetch PC.
- in_pc_taken  in  1  prediction taken.
- in_inst0  in  32  first instruction; already realigned by the producer.
- in_inst1  in  32  second instruction; `INST_NOP when in_pc[2] is set.
- in_badv  in  32  fetch bad virtual address.
- in_exception  in  7  fetch exception code.
- in_excp_flag  in  2  fetch exception flag; nonzero means exception.
- id_allowin  in  1  ID consumes every valid output slot this cycle.
- out0_valid / out1_valid  out  1 each  slot valid.
- out0_pc / out1_pc  out  32 each
- out0_inst / out1_inst  out  32 each
- out0_pc_next / out1_pc_next  out  32 each
- out0_taken / out1_taken  out  1 each
- out0_badv / out1_badv  out  32 each
- out0_exception / out1_exception  out  7 each
- out0_excp_flag / out1_excp_flag  out  2 each

Behaviour:
- State: head and tail pointers (PTR_W bits, wrap modulo DEPTH) and count (PTR_W+1 bits, range 0..DEPTH).
- Push condition: push = fifo_readygo && fifo_allowin.
- Entries per push: n = 1 if in_pc[2] or in_excp_flag != 0, else n = 2.
- First entry written at tail:
  - pc = in_pc, inst = in_inst0, badv/exception/excp_flag from the inputs.
  - If n == 1: pc_next = in_pc_next, taken = in_pc_taken.
  - If n == 2: pc_next = in_pc + 4, taken = 0.
- Second entry (n == 2), written at tail+1:
  - pc = in_pc + 4, inst = in_inst1, pc_next = in_pc_next, taken = in_pc_taken.
  - badv = 0, exception = 0, excp_flag = 0.
- Pop: pop count p = id_allowin ? (out0_valid + out1_valid) : 0.
- Output slots (combinational from the array):
  - out0 reads entry[head]; out0_valid = count >= 1.
  - out1 reads entry[head+1]; out1_valid = count >= 2.
- Update each cycle: tail += push ? n : 0; head += p; count += (push ? n : 0) - p.
- Simultaneous push and pop are both honoured in the same cycle.
- Latency: a pushed packet is visible on out0 the cycle after the push; there is no bypass.
- Backpressure: space_ok and nearly_full are combinational from the current count. A pop in the same cycle does not raise space_ok.
- Full: count == DEPTH gives space_ok = 0, so no push is accepted. Count never exceeds DEPTH.
- Empty: both valids are 0; id_allowin is ignored.
- Wrap: the second entry of a packet and out1 index (pointer+1) mod DEPTH.
- flush and rst:
  - head = tail = count = 0; any same-cycle push or pop is discarded.
  - rst also returns every entry to pc = `PC_RESET, inst = `INST_NOP, pc_next = `PC_RESET+4, other fields 0.
  - flush does not clear entry contents.
- Reset values of outputs:
  - out*_valid = 0; fifo_allowin = space_ok = 1; nearly_full = 0.
  - out*_pc = `PC_RESET, out*_inst = `INST_NOP, out*_pc_next = `PC_RESET+4, remaining data fields 0.
- Invariant: in_* are sampled only when push = 1.

Optional Feature:
- Macro: INST_QUEUE_PERF_EN.
- When defined, adds two 32-bit outputs:
  - iq_empty_cycles: counts cycles with count == 0 and no flush.
  - iq_full_cycles: counts cycles with space_ok == 0.
- Both counters clear only on rst, not on flush, and saturate at 32'hFFFF_FFFF.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- After rst, push in_pc=0x1C000000, inst0=0x11, inst1=0x22, id_allowin=0 -> next cycle out0 = 0x1C000000/0x11 and out1 = 0x1C000004/0x22, count = 2, pc_next of out0 = 0x1C000004.
- Push in_pc=0x1C000014 (pc[2]=1), in_pc_taken=1, in_pc_next=0x1C000100 -> a single entry; out0_taken = 1, out0_pc_next = 0x1C000100, count += 1.
- Push a packet with in_excp_flag=2'b01, in_exception=7'h08, in_badv=0x1C000020 -> one entry only; out0 carries excp_flag 01, exception 08, badv 0x1C000020.
- Fill DEPTH=8 with 4 two-entry packets and id_allowin=0 -> space_ok = fifo_allowin = 0 and nearly_full = 1; a held fifo_readygo is not accepted; count stays 8.
- With 3 entries queued at head=6, push a 2-entry packet while id_allowin=1 -> count goes 3 -> 3, tail wraps 1 -> 3, out0/out1 read entries 0 and 1 in order.
- Flush while count=5 and push is active -> next cycle both valids are 0, count = 0, and the pushed packet is lost.
